square_sequencer: RTL and testbench
===================================

// Module: square_sequencer
// PURPOSE
//  Tone scheduler for the square-wave generator. Queues (period, duration) notes written by the CPU
//  I/O bus and plays them in order by driving the generator's 16-bit period and its active-high reset.
//  Each note runs for dur*TICK_DIV clocks. The generator output stays silent when no note is
//  playing, during rests and while paused.
// PARAMETERS
//  DEPTH     4      note FIFO entries; must be a power of 2 and at least 2
//  TICK_DIV  12000  clocks per duration tick (1 ms at 12 MHz); must be at least 2
// PORTS
//  clk        in   1   system clock; all logic on rising edge
//  resetq     in   1   synchronous, active-low reset
//  wr_valid   in   1   note write strobe
//  wr_ready   out  1   FIFO can accept a note
//  wr_period  in   16  note half-period for the generator; 0 = rest
//  wr_dur     in   16  note length in ticks; 0 is treated as 1
//  flush      in   1   drop queue and current note
//  pause      in   1   freeze current note
//  period     out  16  to generator period input (registered)
//  sq_reset   out  1   to generator reset, active-high (registered); 1 = silent or restart
//  busy       out  1   state != IDLE, or level != 0
//  level      out  $clog2(DEPTH)+1  FIFO occupancy, 0..DEPTH
// BEHAVIOUR
//  Reset state (resetq=0 at an edge):
//   - FIFO empty, state=IDLE, period=0, sq_reset=1, presc=0, remain=0.
//   - Outputs: busy=0, wr_ready=1, level=0.
//   - Reset mid-note aborts the note with the same result.
//  Write side:
//   - wr_ready = (level != DEPTH) && !flush.
//   - A note is accepted on an edge where wr_valid && wr_ready; {wr_period,wr_dur} goes to the tail.
//   - If a push and a pop happen on the same edge, level is unchanged.
//  FSM states: IDLE, PLAY, PAUSED.
//   - START event (an edge that pops the head note):
//     period<=head.period; remain<=max(head.dur,1); presc<=0; sq_reset<=1; state<=PLAY.
//   - IDLE: if level != 0 -> START. A note written into an empty queue appears on `period` one edge
//     after the edge that accepted it.
//   - PLAY, pause=0:
//     - sq_reset<=(period==0). This gives a 1-cycle restart pulse for a tone, and keeps the rest
//       state silent.
//     - presc increments each cycle.
//     - When presc==TICK_DIV-1: presc<=0 and remain decrements.
//     - If remain==1 at that point, the note ends: START if level != 0 (no gap cycle between
//       notes); otherwise IDLE, period<=0, sq_reset<=1.
//     - Net result: a note occupies exactly 1 + max(dur,1)*TICK_DIV - 1 = max(dur,1)*TICK_DIV clocks
//       between START edges.
//   - PLAY, pause=1: state<=PAUSED, sq_reset<=1. presc and remain hold their values.
//   - PAUSED:
//     - Holds presc, remain and period, with sq_reset=1.
//     - When pause=0: state<=PLAY, sq_reset<=(period==0). The note resumes its remaining time, and
//       the waveform phase restarts.
//   - pause in IDLE is ignored, so a queued note still starts.
//  flush (highest priority after reset):
//   - On that edge: FIFO emptied, state<=IDLE, period<=0, sq_reset<=1, presc and remain cleared.
//   - A same-cycle write is not accepted (wr_ready=0).
//  Counters:
//   - presc is wide enough for TICK_DIV-1; remain is 16 bits.
//   - FIFO pointers wrap modulo DEPTH; level is one bit wider than the pointers, to distinguish full
//     from empty.
// TESTING (TICK_DIV=4, DEPTH=4)
//  1 resetq=0 for 2 clk -> period=0, sq_reset=1, busy=0, level=0, wr_ready=1.
//  2 Write {3,2} from IDLE:
//    - period=3 one edge after accept, with sq_reset=1 for exactly 1 cycle, then 0.
//    - After 8 clocks: period=0, sq_reset=1, busy=0.
//  3 Write {3,1} then {5,1} back-to-back:
//    - period=3 for 4 clocks, then period=5 with a 1-cycle sq_reset pulse and no IDLE cycle.
//    - IDLE 4 clocks later.
//  4 Write {7,100}, then 5 more writes:
//    - level reaches 4 and wr_ready=0; the 5th write stalls.
//    - After flush: level=0, period=0, IDLE; the 5th write is not accepted in the flush cycle.
//  5 Write rest {0,2} -> sq_reset=1 and busy=1 for 8 clocks; dur=0 note plays 4 clocks.
//  6 Write {3,2}:
//    - pause=1 for 10 clocks after 3 PLAY cycles -> sq_reset=1 and presc frozen.
//    - After release, period=3 for the remaining 5 clocks, then IDLE.

Source files
------------

// File: rtl/square_sequencer.sv
// Tone scheduler: queues (period, duration) notes and plays them in order by
// driving a square-wave generator's period and active-high reset.
module square_sequencer #(
  parameter int DEPTH    = 4,
  parameter int TICK_DIV = 12000
) (
  input  logic                     clk,
  input  logic                     resetq,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic [15:0]              wr_period,
  input  logic [15:0]              wr_dur,
  input  logic                     flush,
  input  logic                     pause,
  output logic [15:0]              period,
  output logic                     sq_reset,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PW  = $clog2(DEPTH);
  localparam int LW  = PW + 1;
  localparam int PSW = $clog2(TICK_DIV);

  typedef enum logic [1:0] {IDLE, PLAY, PAUSED} state_t;

  state_t          r_state;
  logic [15:0]     r_fifo_period [DEPTH];
  logic [15:0]     r_fifo_dur    [DEPTH];
  logic [PW-1:0]   r_wptr;
  logic [PW-1:0]   r_rptr;
  logic [LW-1:0]   r_level;
  logic [PSW-1:0]  r_presc;
  logic [15:0]     r_remain;
  logic [15:0]     r_period;
  logic            r_sq_reset;

  logic            w_push;
  logic            w_tick_end;
  logic            w_note_end;
  logic            w_start;
  logic [15:0]     w_head_period;
  logic [15:0]     w_head_dur;

  assign wr_ready      = (r_level != LW'(DEPTH)) && !flush;
  assign w_push        = wr_valid && wr_ready;
  assign w_head_period = r_fifo_period[r_rptr];
  assign w_head_dur    = r_fifo_dur[r_rptr];
  assign w_tick_end    = (r_presc == PSW'(TICK_DIV - 1));
  assign w_note_end    = (r_state == PLAY) && !pause && w_tick_end && (r_remain == 16'd1);
  // A pop happens from IDLE or at the very end of a note, so back-to-back notes have no gap.
  assign w_start       = !flush && (r_level != '0) && ((r_state == IDLE) || w_note_end);

  assign period   = r_period;
  assign sq_reset = r_sq_reset;
  assign level    = r_level;
  assign busy     = (r_state != IDLE) || (r_level != '0);

  // Note storage holds data only; validity is tracked by the pointers and level.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_period[r_wptr] <= wr_period;
      r_fifo_dur[r_wptr]    <= wr_dur;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetq || flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_push)  r_wptr <= r_wptr + PW'(1);
      if (w_start) r_rptr <= r_rptr + PW'(1);
      case ({w_push, w_start})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetq || flush) begin
      r_state    <= IDLE;
      r_period   <= 16'd0;
      r_sq_reset <= 1'b1;
      r_presc    <= '0;
      r_remain   <= 16'd0;
    end else if (w_start) begin
      r_state    <= PLAY;
      r_period   <= w_head_period;
      r_sq_reset <= 1'b1;
      r_presc    <= '0;
      r_remain   <= (w_head_dur == 16'd0) ? 16'd1 : w_head_dur;
    end else begin
      case (r_state)
        IDLE: begin
          r_sq_reset <= 1'b1;
        end
        PLAY: begin
          if (pause) begin
            r_state    <= PAUSED;
            r_sq_reset <= 1'b1;
          end else begin
            // Rests keep the generator held in reset for their whole length.
            r_sq_reset <= (r_period == 16'd0);
            if (w_tick_end) begin
              r_presc <= '0;
              if (r_remain == 16'd1) begin
                r_state    <= IDLE;
                r_period   <= 16'd0;
                r_sq_reset <= 1'b1;
                r_remain   <= 16'd0;
              end else begin
                r_remain <= r_remain - 16'd1;
              end
            end else begin
              r_presc <= r_presc + PSW'(1);
            end
          end
        end
        PAUSED: begin
          if (!pause) begin
            r_state    <= PLAY;
            r_sq_reset <= (r_period == 16'd0);
          end else begin
            r_sq_reset <= 1'b1;
          end
        end
        default: begin
          r_state    <= IDLE;
          r_period   <= 16'd0;
          r_sq_reset <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_square_sequencer.sv
// Bench for square_sequencer: directed table, hand-written corner sequences
// and randomized traffic checked against a note-level reference model.
module tb_square_sequencer;

  localparam int DEPTH    = 4;
  localparam int TICK_DIV = 4;

  logic        clk = 1'b0;
  logic        resetq;
  logic        wr_valid;
  logic        wr_ready;
  logic [15:0] wr_period;
  logic [15:0] wr_dur;
  logic        flush;
  logic        pause;
  logic [15:0] period;
  logic        sq_reset;
  logic        busy;
  logic [2:0]  level;

  square_sequencer #(.DEPTH(DEPTH), .TICK_DIV(TICK_DIV)) dut (
    .clk(clk), .resetq(resetq), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_period(wr_period), .wr_dur(wr_dur), .flush(flush), .pause(pause),
    .period(period), .sq_reset(sq_reset), .busy(busy), .level(level)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of pending notes plus the note now sounding,
  // counted in clocks left rather than prescaler/tick counters.
  typedef struct { int p; int d; } note_t;
  note_t q[$];
  bit    m_playing, m_paused, m_fresh;
  int    m_period, m_left;

  task automatic model_clear();
    q.delete();
    m_playing = 0; m_paused = 0; m_fresh = 0; m_period = 0; m_left = 0;
  endtask

  task automatic model_edge();
    int    pre;
    bit    do_push, do_start;
    note_t n;
    if (!resetq || flush) begin
      model_clear();
      return;
    end
    pre      = q.size();
    do_push  = wr_valid && (pre != DEPTH);
    do_start = 0;
    m_fresh  = 0;
    if (!m_playing)      do_start = (pre != 0);
    else if (m_paused)   begin if (!pause) m_paused = 0; end
    else if (pause)      m_paused = 1;
    else if (m_left == 0) begin
      if (pre != 0) do_start = 1;
      else begin m_playing = 0; m_period = 0; end
    end else m_left--;
    if (do_start) begin
      n = q.pop_front();
      m_playing = 1; m_paused = 0; m_fresh = 1; m_period = n.p;
      m_left = ((n.d == 0) ? 1 : n.d) * TICK_DIV - 1;
    end
    if (do_push) begin
      n.p = int'(wr_period); n.d = int'(wr_dur);
      q.push_back(n);
    end
  endtask

  task automatic check_model();
    chk("period",   int'(period),   m_period);
    chk("sq_reset", int'(sq_reset), int'(!m_playing || m_paused || m_fresh || m_period == 0));
    chk("busy",     int'(busy),     int'(m_playing || q.size() != 0));
    chk("level",    int'(level),    q.size());
    chk("wr_ready", int'(wr_ready), int'(q.size() != DEPTH && !flush));
  endtask

  task automatic cyc(input bit v, input int p, input int d, input bit fl, input bit pa);
    @(negedge clk);
    resetq = 1'b1; wr_valid = v; wr_period = 16'(p); wr_dur = 16'(d); flush = fl; pause = pa;
    @(posedge clk);
    model_edge();
    #1;
    check_model();
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0);
  endtask

  typedef struct {
    bit rstq; bit v; int p; int d;
    int e_period; bit e_sqr; bit e_busy; int e_level; bit e_rdy;
  } vec_t;
  vec_t tbl[12];

  initial begin
    resetq = 1'b0; wr_valid = 1'b0; wr_period = '0; wr_dur = '0; flush = 1'b0; pause = 1'b0;
    model_clear();

    // Reset, then a single {3,2} note: START one edge after accept, 8 clocks long.
    tbl[0]  = '{0, 0, 0, 0, 0, 1, 0, 0, 1};
    tbl[1]  = '{0, 0, 0, 0, 0, 1, 0, 0, 1};
    tbl[2]  = '{1, 1, 3, 2, 0, 1, 1, 1, 1};
    tbl[3]  = '{1, 0, 0, 0, 3, 1, 1, 0, 1};
    tbl[4]  = '{1, 0, 0, 0, 3, 0, 1, 0, 1};
    for (int i = 5; i <= 10; i++) tbl[i] = '{1, 0, 0, 0, 3, 0, 1, 0, 1};
    tbl[11] = '{1, 0, 0, 0, 0, 1, 0, 0, 1};

    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      resetq = tbl[i].rstq; wr_valid = tbl[i].v;
      wr_period = 16'(tbl[i].p); wr_dur = 16'(tbl[i].d); flush = 1'b0; pause = 1'b0;
      @(posedge clk);
      model_edge();
      #1;
      chk($sformatf("tbl%0d.period", i),   int'(period),   tbl[i].e_period);
      chk($sformatf("tbl%0d.sq_reset", i), int'(sq_reset), int'(tbl[i].e_sqr));
      chk($sformatf("tbl%0d.busy", i),     int'(busy),     int'(tbl[i].e_busy));
      chk($sformatf("tbl%0d.level", i),    int'(level),    tbl[i].e_level);
      chk($sformatf("tbl%0d.wr_ready", i), int'(wr_ready), int'(tbl[i].e_rdy));
    end

    // Back-to-back notes with no idle cycle between them.
    cyc(1, 3, 1, 0, 0);
    cyc(1, 5, 1, 0, 0);
    idle_cycles(4);
    chk("b2b.period5", int'(period), 5);
    chk("b2b.restart", int'(sq_reset), 1);
    idle_cycles(5);
    chk("b2b.idle", int'(busy), 0);

    // Fill the queue, stall a write, then flush with a write pending.
    cyc(1, 7, 100, 0, 0);
    for (int i = 0; i < 5; i++) cyc(1, 11 + i, 1, 0, 0);
    chk("full.level", int'(level), 4);
    chk("full.ready", int'(wr_ready), 0);
    cyc(1, 9, 1, 1, 0);
    chk("flush.level", int'(level), 0);
    chk("flush.period", int'(period), 0);
    cyc(0, 0, 0, 0, 0);
    chk("flush.noaccept", int'(busy), 0);

    // Rest note, then a zero-duration note.
    cyc(1, 0, 2, 0, 0);
    idle_cycles(9);
    chk("rest.done", int'(busy), 0);
    cyc(1, 9, 0, 0, 0);
    idle_cycles(5);
    chk("dur0.done", int'(busy), 0);

    // Pause in the middle of a note, then resume; pause while idle is ignored.
    cyc(1, 3, 2, 0, 1);
    cyc(0, 0, 0, 0, 0);
    idle_cycles(3);
    for (int i = 0; i < 10; i++) cyc(0, 0, 0, 0, 1);
    chk("pause.silent", int'(sq_reset), 1);
    idle_cycles(8);
    chk("pause.done", int'(busy), 0);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      resetq    = ($urandom_range(0, 499) != 0);
      flush     = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 29) == 0) pause = ~pause;
      wr_valid  = ($urandom_range(0, 2) == 0);
      wr_period = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom_range(1, 65535));
      wr_dur    = 16'($urandom_range(0, 3));
      @(posedge clk);
      model_edge();
      #1;
      check_model();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
